// File: rtl/mu02_acc_cpu.sv
// mu02_acc_cpu: accumulator CPU with a unified program/data memory and HALT/FETCH/EXEC sequencing.
module mu02_acc_cpu #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = DATA_W - 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_wdata,
  output logic [DATA_W-1:0] prog_rdata,
  output logic              halted,
  output logic [DATA_W-1:0] acc_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              carry,
  output logic              ovf
);
  if (DATA_W < 8 || DATA_W > 32 || ADDR_W != DATA_W - 4) begin : g_bad_params
    $error("mu02_acc_cpu: DATA_W must be 8..32 and ADDR_W must equal DATA_W-4");
  end
  localparam logic [3:0] OP_LDA = 4'h0, OP_LDAI = 4'h8, OP_STO = 4'h1, OP_ADD = 4'h2,
                         OP_ADDI = 4'hA, OP_SUB = 4'h3, OP_SUBI = 4'hB, OP_JMP = 4'h4,
                         OP_JGE = 4'h5, OP_JNE = 4'h6, OP_JC = 4'hC, OP_STP = 4'h7;
  typedef enum logic [1:0] {HALT, FETCH, EXEC} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] ir, acc, imm, src, res, mem_wd;
  logic [DATA_W:0]   sum, diff;
  logic [ADDR_W-1:0] pc, op, mem_wa;
  logic [3:0]        opc;
  logic              is_add, is_sub, arith_ovf, taken, mem_we;
  assign opc        = ir[DATA_W-1 -: 4];
  assign op         = ir[ADDR_W-1:0];
  assign imm        = {{(DATA_W-ADDR_W){op[ADDR_W-1]}}, op};
  // Opcode bit 3 selects the immediate form of loads and arithmetic
  assign src        = opc[3] ? imm : mem[op];
  assign sum        = {1'b0, acc} + {1'b0, src};
  assign diff       = {1'b0, acc} - {1'b0, src};
  assign is_add     = opc == OP_ADD || opc == OP_ADDI;
  assign is_sub     = opc == OP_SUB || opc == OP_SUBI;
  assign res        = is_add ? sum[DATA_W-1:0] : diff[DATA_W-1:0];
  assign arith_ovf  = (is_add ? acc[DATA_W-1] == src[DATA_W-1] : acc[DATA_W-1] != src[DATA_W-1])
                      && res[DATA_W-1] != acc[DATA_W-1];
  assign taken      = opc == OP_JMP || (opc == OP_JGE && !acc[DATA_W-1]) ||
                      (opc == OP_JNE && |acc) || (opc == OP_JC && carry);
  assign prog_rdata = mem[prog_addr];
  assign halted     = state == HALT;
  assign acc_out    = acc;
  assign pc_out     = pc;
  always_comb begin
    state_nx = state;
    mem_we   = 1'b0;
    mem_wa   = prog_addr;
    mem_wd   = prog_wdata;
    case (state)
      HALT: begin
        mem_we   = prog_we;
        state_nx = start ? FETCH : HALT;
      end
      FETCH: state_nx = EXEC;
      EXEC: begin
        mem_we   = opc == OP_STO;
        mem_wa   = op;
        mem_wd   = acc;
        state_nx = opc == OP_STP ? HALT : FETCH;
      end
      default: state_nx = HALT;
    endcase
  end
  // Memory is never cleared; reset only suppresses a write in flight
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[mem_wa] <= mem_wd;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= HALT;
      pc    <= '0;
      acc   <= '0;
      ir    <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == HALT && start) ovf <= 1'b0;
      if (state == FETCH) begin
        ir <= mem[pc];
        pc <= pc + ADDR_W'(1);
      end
      if (state == EXEC) begin
        if (taken) pc <= op;
        if (opc == OP_LDA || opc == OP_LDAI) acc <= src;
        if (is_add || is_sub) begin
          acc   <= res;
          carry <= is_add ? sum[DATA_W] : diff[DATA_W];
          ovf   <= ovf | arith_ovf;
        end
      end
    end
  end
endmodule

// File: tb/tb_mu02_acc_cpu.sv
// tb_mu02_acc_cpu: vector table, hand-written corner sequences and randomized programs against a reference model.
module tb_mu02_acc_cpu;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, prog_we, halted, carry, ovf;
  logic [11:0] prog_addr, pc_out;
  logic [15:0] prog_wdata, prog_rdata, acc_out;
  logic reset8, start8, prog_we8, halted8, carry8, ovf8;
  logic [3:0] prog_addr8, pc8;
  logic [7:0] prog_wdata8, prog_rdata8, acc8;

  mu02_acc_cpu dut (
    .clk(clk), .reset(reset), .start(start), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .prog_rdata(prog_rdata), .halted(halted), .acc_out(acc_out),
    .pc_out(pc_out), .carry(carry), .ovf(ovf)
  );
  mu02_acc_cpu #(.DATA_W(8), .ADDR_W(4)) dut8 (
    .clk(clk), .reset(reset8), .start(start8), .prog_we(prog_we8), .prog_addr(prog_addr8),
    .prog_wdata(prog_wdata8), .prog_rdata(prog_rdata8), .halted(halted8), .acc_out(acc8),
    .pc_out(pc8), .carry(carry8), .ovf(ovf8)
  );

  int nvec = 0, nfail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic load(input logic [11:0] a, input logic [15:0] d);
    @(negedge clk); prog_we = 1'b1; prog_addr = a; prog_wdata = d;
    @(negedge clk); prog_we = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [15:0] d);
    prog_addr = a;
    #1 d = prog_rdata;
  endtask

  task automatic run(input int maxc, output int cyc);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!halted && cyc < maxc) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  typedef struct {
    string           name;
    logic [11:0]     daddr;
    logic [15:0]     dval;
    int              n;
    logic [5:0][15:0] prog;
    logic [15:0]     acc;
    logic            c, v;
    logic [11:0]     pc;
    int              cyc;
    logic [11:0]     caddr;
    logic [15:0]     cval;
  } vec_t;
  vec_t vt [6];

  // Reference model: instruction-level interpreter using signed integer arithmetic
  logic [15:0] mm [4096];
  logic [11:0] m_pc;
  logic [15:0] m_acc;
  logic        m_c, m_v, m_halt;

  task automatic model_step;
    logic [15:0] w, src;
    logic [3:0]  o;
    logic [11:0] a;
    int r;
    if (m_halt) return;
    w = mm[m_pc];
    m_pc = m_pc + 12'd1;
    o = w[15:12];
    a = w[11:0];
    src = o[3] ? 16'($signed(a)) : mm[a];
    case (o)
      4'h0, 4'h8: m_acc = src;
      4'h1: mm[a] = m_acc;
      4'h2, 4'hA: begin
        r = int'($signed(m_acc)) + int'($signed(src));
        m_c = (int'(m_acc) + int'(src)) > 65535;
        if (r > 32767 || r < -32768) m_v = 1'b1;
        m_acc = m_acc + src;
      end
      4'h3, 4'hB: begin
        r = int'($signed(m_acc)) - int'($signed(src));
        m_c = m_acc < src;
        if (r > 32767 || r < -32768) m_v = 1'b1;
        m_acc = m_acc - src;
      end
      4'h4: m_pc = a;
      4'h5: if ($signed(m_acc) >= 0) m_pc = a;
      4'h6: if (m_acc != 0) m_pc = a;
      4'hC: if (m_c) m_pc = a;
      4'h7: m_halt = 1'b1;
      default: ;
    endcase
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] d;
    logic [3:0]  ops [14];
    logic [3:0]  o;
    logic [11:0] a;
    int cyc;
    reset = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    reset8 = 1'b1; start8 = 1'b0; prog_we8 = 1'b0; prog_addr8 = '0; prog_wdata8 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0; reset8 = 1'b0;
    chk("reset.halted", halted, 1); chk("reset.pc", pc_out, 0); chk("reset.acc", acc_out, 0);
    chk("reset.carry", carry, 0); chk("reset.ovf", ovf, 0);

    vt[0] = '{"ovf_add", 12'h100, 16'h7FFF, 4, {16'h0, 16'h0, 16'h7000, 16'h1FFF, 16'hA001, 16'h0100},
              16'h8000, 1'b0, 1'b1, 12'h004, 8, 12'hFFF, 16'h8000};
    vt[1] = '{"jge_nt", 12'h100, 16'h7FFF, 4, {16'h0, 16'h0, 16'h7000, 16'h5005, 16'hB001, 16'h8000},
              16'hFFFF, 1'b1, 1'b0, 12'h004, 8, 12'h100, 16'h7FFF};
    vt[2] = '{"countdown", 12'h100, 16'h7FFF, 4, {16'h0, 16'h0, 16'h7000, 16'h6001, 16'hB001, 16'h8003},
              16'h0000, 1'b0, 1'b0, 12'h004, 16, 12'h002, 16'h6001};
    vt[3] = '{"jc_taken", 12'h100, 16'h7FFF, 5, {16'h0, 16'h7000, 16'h8005, 16'hC004, 16'hA001, 16'h8FFF},
              16'h0000, 1'b1, 1'b0, 12'h005, 8, 12'h003, 16'h8005};
    vt[4] = '{"ovf_sub", 12'h100, 16'h7FFF, 3, {16'h0, 16'h0, 16'h0, 16'h7000, 16'h3100, 16'h8800},
              16'h7801, 1'b0, 1'b1, 12'h003, 6, 12'h100, 16'h7FFF};
    vt[5] = '{"jmp_nop", 12'h100, 16'h7FFF, 6, {16'h7000, 16'h8123, 16'hD000, 16'h7000, 16'h7000, 16'h4003},
              16'h0123, 1'b0, 1'b0, 12'h006, 8, 12'h001, 16'h7000};
    foreach (vt[i]) begin
      do_reset;
      load(vt[i].daddr, vt[i].dval);
      for (int j = 0; j < vt[i].n; j++) load(12'(j), vt[i].prog[j]);
      run(200, cyc);
      chk({vt[i].name, ".halted"}, halted, 1);
      chk({vt[i].name, ".cycles"}, cyc, vt[i].cyc);
      chk({vt[i].name, ".acc"}, acc_out, vt[i].acc);
      chk({vt[i].name, ".pc"}, pc_out, vt[i].pc);
      chk({vt[i].name, ".carry"}, carry, vt[i].c);
      chk({vt[i].name, ".ovf"}, ovf, vt[i].v);
      rd(vt[i].caddr, d);
      chk({vt[i].name, ".mem"}, d, vt[i].cval);
    end

    // ovf stays set through later instructions and is cleared by the next start
    do_reset;
    load(12'h100, 16'h7FFF);
    load(0, 16'h0100); load(1, 16'hA001); load(2, 16'h8000); load(3, 16'h7000);
    load(4, 16'h8001); load(5, 16'h7000);
    run(50, cyc);
    chk("sticky.ovf", ovf, 1); chk("sticky.acc", acc_out, 0);
    run(50, cyc);
    chk("restart.ovf", ovf, 0); chk("restart.acc", acc_out, 1); chk("restart.pc", pc_out, 6);

    // reset during the EXEC of STO aborts the write
    do_reset;
    load(12'h100, 16'h1234);
    load(0, 16'h8055); load(1, 16'h1100); load(2, 16'h7000);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("sto_abort.halted", halted, 1); chk("sto_abort.pc", pc_out, 0); chk("sto_abort.acc", acc_out, 0);
    rd(12'h100, d);
    chk("sto_abort.mem", d, 16'h1234);
    run(50, cyc);
    rd(12'h100, d);
    chk("sto_commit.mem", d, 16'h0055);

    // start and prog_we together in HALT; prog_we during FETCH ignored
    do_reset;
    load(12'h200, 16'h1111); load(1, 16'h7000);
    @(negedge clk); prog_we = 1'b1; prog_addr = 12'h000; prog_wdata = 16'h87FF; start = 1'b1;
    @(negedge clk); start = 1'b0; prog_addr = 12'h200; prog_wdata = 16'hBEEF;
    @(negedge clk); prog_we = 1'b0;
    cyc = 0;
    while (!halted && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("we_start.halted", halted, 1); chk("we_start.acc", acc_out, 16'h07FF);
    rd(12'h000, d); chk("we_start.mem0", d, 16'h87FF);
    rd(12'h200, d); chk("fetch_we.mem", d, 16'h1111);

    // reset wins over start and prog_we
    @(negedge clk); reset = 1'b1; start = 1'b1; prog_we = 1'b1; prog_addr = 12'h200; prog_wdata = 16'h2222;
    @(negedge clk); reset = 1'b0; start = 1'b0; prog_we = 1'b0;
    @(negedge clk);
    chk("rst_prio.halted", halted, 1);
    rd(12'h200, d); chk("rst_prio.mem", d, 16'h1111);

    // randomized programs confined to 0x000..0x00F with data at 0x100..0x107
    ops = '{4'h0, 4'h8, 4'h1, 4'h2, 4'hA, 4'h3, 4'hB, 4'h4, 4'h5, 4'h6, 4'hC, 4'h7, 4'hD, 4'h9};
    for (int t = 0; t < 15; t++) begin
      do_reset;
      for (int i = 0; i < 15; i++) begin
        o = ops[$urandom_range(0, 13)];
        if (o == 4'h7 && $urandom_range(0, 3) != 0) o = 4'hD;
        a = (o inside {4'h0, 4'h1, 4'h2, 4'h3}) ? 12'h100 + 12'($urandom_range(0, 7)) :
            (o inside {4'h4, 4'h5, 4'h6, 4'hC}) ? 12'($urandom_range(0, 15)) : 12'($urandom);
        mm[i] = {o, a};
        load(12'(i), mm[i]);
      end
      mm[15] = 16'h4000;
      load(12'd15, mm[15]);
      for (int i = 0; i < 8; i++) begin
        mm[12'h100 + i] = 16'($urandom);
        load(12'h100 + 12'(i), mm[12'h100 + i]);
      end
      m_pc = '0; m_acc = '0; m_c = 1'b0; m_v = 1'b0; m_halt = 1'b0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (40) @(negedge clk);
      for (int k = 0; k < 20; k++) model_step;
      chk($sformatf("rand%0d.acc", t), acc_out, m_acc);
      chk($sformatf("rand%0d.pc", t), pc_out, m_pc);
      chk($sformatf("rand%0d.carry", t), carry, m_c);
      chk($sformatf("rand%0d.ovf", t), ovf, m_v);
      chk($sformatf("rand%0d.halted", t), halted, m_halt);
      for (int i = 0; i < 8; i++) begin
        rd(12'h100 + 12'(i), d);
        chk($sformatf("rand%0d.mem%0d", t, i), d, mm[12'h100 + i]);
      end
    end

    // 8-bit build: short arithmetic program, then PC wrap without STP
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); prog_we8 = 1'b1; prog_addr8 = 4'(i);
      prog_wdata8 = (i == 0) ? 8'h87 : (i < 3) ? 8'hA7 : 8'hD0;
      @(negedge clk); prog_we8 = 1'b0;
    end
    @(negedge clk); start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    repeat (6) @(negedge clk);
    chk("w8.acc", acc8, 8'h15); chk("w8.carry", carry8, 0); chk("w8.ovf", ovf8, 0); chk("w8.pc", pc8, 3);
    repeat (24) @(negedge clk);
    chk("w8.pc_f", pc8, 4'hF);
    repeat (2) @(negedge clk);
    chk("w8.pc_wrap", pc8, 4'h0); chk("w8.running", halted8, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/mu02_acc_cpu.md
MU02_ACC_CPU -- requirements
Module: mu02

Interface
REQ-001 Parameter DATA_W, default 16: accumulator, instruction and memory word width; legal range 8..32.
REQ-002 Parameter ADDR_W, default DATA_W-4: operand/PC width; memory depth 2**ADDR_W words; any other value is illegal and the design SHALL flag it at elaboration.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 start  input  1  one-cycle pulse; leaves HALT and begins execution at pc.
REQ-006 prog_we  input  1  program/data write strobe, honoured only in HALT.
REQ-007 prog_addr  input  ADDR_W  load/readback address.
REQ-008 prog_wdata  input  DATA_W  load data.
REQ-009 prog_rdata  output  DATA_W  combinational mem[prog_addr], valid in every state.
REQ-010 halted  output  1  high while state == HALT.
REQ-011 acc_out  output  DATA_W  accumulator value.
REQ-012 pc_out  output  ADDR_W  program counter value.
REQ-013 carry  output  1  carry/borrow of the last arithmetic instruction.
REQ-014 ovf  output  1  sticky signed-overflow flag.

Function
REQ-015 States: HALT, FETCH, EXEC; HALT->FETCH on start; FETCH->EXEC always; EXEC->FETCH, except EXEC->HALT on STP.
REQ-016 FETCH: ir <= mem[pc]; pc <= pc+1, wrapping from 2**ADDR_W-1 to 0.
REQ-017 Instruction: opcode = ir[DATA_W-1:DATA_W-4], operand = ir[ADDR_W-1:0]; imm = operand sign-extended to DATA_W.
REQ-018 EXEC opcodes: 0000 LDA acc<=mem[op]; 1000 LDAI acc<=imm; 0001 STO mem[op]<=acc; 0010 ADD acc+mem[op]; 1010 ADDI acc+imm; 0011 SUB acc-mem[op]; 1011 SUBI acc-imm.
REQ-019 EXEC jumps: 0100 JMP pc<=op; 0101 JGE taken iff acc[DATA_W-1]==0 (signed acc>=0); 0110 JNE taken iff acc!=0; 1100 JC taken iff carry==1; not-taken leaves pc as incremented in FETCH.
REQ-020 0111 STP enters HALT; pc keeps the already-incremented value; all other opcodes are NOPs (one FETCH+EXEC, no state change).
REQ-021 Arithmetic is DATA_W-bit modulo; ADD/ADDI carry = bit DATA_W of unsigned sum; SUB/SUBI carry = 1 iff unsigned acc < subtrahend (borrow).
REQ-022 ovf is set when operands of ADD/ADDI share a sign differing from the result's, or SUB/SUBI operands differ in sign and result sign differs from acc's; ovf is cleared only by reset or start.
REQ-023 carry updates only on ADD/ADDI/SUB/SUBI; other instructions hold it.
REQ-024 Memory read is combinational; STO write commits at the EXEC clock edge and is visible to the next FETCH.
REQ-025 In HALT, prog_we=1 writes prog_wdata to mem[prog_addr] at the clock edge; prog_we outside HALT is ignored.
REQ-026 prog_we and start in the same HALT cycle: write is performed and state goes to FETCH.
REQ-027 start outside HALT is ignored.
REQ-028 Each instruction takes exactly 2 cycles; first FETCH occurs the cycle after start is sampled.

Reset
REQ-029 reset=1 at a clock edge: state<=HALT, pc<=0, acc<=0, ir<=0, carry<=0, ovf<=0, regardless of current state.
REQ-030 Memory contents are not cleared by reset; a reset mid-program aborts the pending instruction (no STO write in that cycle).
REQ-031 reset has priority over start and prog_we in the same cycle.

Verification
REQ-032 Load 0x7FFF at 0x100, program LDA 0x100; ADDI 0x001; STO 0xFFF; STP; start -> halted after 8 cycles, mem[0xFFF]=0x8000, ovf=1, carry=0.
REQ-033 Program LDAI 0x000; SUBI 0x001; JGE 0x005; STP; ... -> acc=0xFFFF, carry=1, ovf=0, JGE not taken, halts with pc_out=0x004.
REQ-034 Countdown LDAI 3; SUBI 1; JNE 0x001; STP -> halts exactly 16 cycles after start, acc=0, ovf=0.
REQ-035 Assert reset during the EXEC of a STO -> target word unchanged, pc_out=0, acc_out=0, halted=1 next cycle; readback via prog_rdata.
REQ-036 start with prog_we in one HALT cycle, writing LDAI 0x7FF at 0x000 -> runs it; acc=0x07FF; prog_we during FETCH leaves memory unchanged.
REQ-037 DATA_W=8 (ADDR_W=4) build: LDAI 0x7; ADDI 0x7; ADDI 0x7 (mem[0..2]) -> acc=0x15, carry=0, ovf=0; PC wraps 0xF->0x0 on a program without STP.
